// File: rtl/ov5642_pwr_seq.sv
// OV5642 power-up/reset sequencer ahead of sccb_top: PWDN/RESETB timing, sccb reset, init start and retry.
// Outputs are registered from the state being entered, so each one changes in the first cycle of its new state.
module ov5642_pwr_seq #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int T_PWR_US  = 5_000,
  parameter int T_RST_US  = 1_000,
  parameter int T_BOOT_US = 20_000,
  parameter int T_INIT_US = 2_000_000,
  parameter int MAX_RETRY = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_restart,
  input  logic       i_init_done,
  input  logic       i_init_err,
  output logic       o_cam_pwdn,
  output logic       o_cam_resetb,
  output logic       o_sccb_rst,
  output logic       o_start_init,
  output logic       o_cam_ready,
  output logic       o_fail,
  output logic [1:0] o_retry_cnt,
  output logic [2:0] o_state
);

  localparam logic [2:0] POR_WAIT  = 3'd0;
  localparam logic [2:0] PWDN_REL  = 3'd1;
  localparam logic [2:0] RST_REL   = 3'd2;
  localparam logic [2:0] ARM       = 3'd3;
  localparam logic [2:0] START     = 3'd4;
  localparam logic [2:0] WAIT_INIT = 3'd5;
  localparam logic [2:0] DONE      = 3'd6;
  localparam logic [2:0] FAIL      = 3'd7;

  function automatic logic [31:0] ticks(input longint us);
    longint t;
    t = us * longint'(CLK_FREQ / 1_000_000);
    if (t < 64'sd1) t = 64'sd1;
    return t[31:0];
  endfunction

  localparam logic [31:0] LD_PWR  = ticks(longint'(T_PWR_US)) - 32'd1;
  localparam logic [31:0] LD_RST  = ticks(longint'(T_RST_US)) - 32'd1;
  localparam logic [31:0] LD_BOOT = ticks(longint'(T_BOOT_US)) - 32'd1;
  localparam logic [31:0] LD_INIT = ticks(longint'(T_INIT_US)) - 32'd1;
  localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRY);

  logic [2:0]  state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [1:0]  retry, retry_nxt;
  logic        cnt_zero;
  logic        init_fail;

  assign cnt_zero = (cnt == 32'd0);
  // error beats done in the same cycle; a timeout only counts when done is absent
  assign init_fail = i_init_err || (cnt_zero && !i_init_done);

  always_comb begin
    state_nxt = state;
    retry_nxt = retry;
    case (state)
      POR_WAIT:  if (cnt_zero) state_nxt = PWDN_REL;
      PWDN_REL:  if (cnt_zero) state_nxt = RST_REL;
      RST_REL:   if (cnt_zero) state_nxt = ARM;
      ARM:       state_nxt = START;
      START:     state_nxt = WAIT_INIT;
      WAIT_INIT: begin
        if (init_fail) begin
          if (retry < RETRY_MAX) begin
            retry_nxt = retry + 2'd1;
            state_nxt = POR_WAIT;
          end else begin
            state_nxt = FAIL;
          end
        end else if (i_init_done) begin
          state_nxt = DONE;
        end
      end
      DONE, FAIL: begin
        if (i_restart) begin
          retry_nxt = 2'd0;
          state_nxt = POR_WAIT;
        end
      end
      default:   state_nxt = POR_WAIT;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt_zero ? 32'd0 : cnt - 32'd1;
    if (state_nxt != state) begin
      case (state_nxt)
        POR_WAIT:  cnt_nxt = LD_PWR;
        PWDN_REL:  cnt_nxt = LD_RST;
        RST_REL:   cnt_nxt = LD_BOOT;
        WAIT_INIT: cnt_nxt = LD_INIT;
        default:   cnt_nxt = 32'd0;
      endcase
    end
  end

  // Reset is itself an entry into POR_WAIT, so the counter takes that state's load.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= POR_WAIT;
      cnt          <= LD_PWR;
      retry        <= 2'd0;
      o_cam_pwdn   <= 1'b1;
      o_cam_resetb <= 1'b0;
      o_sccb_rst   <= 1'b1;
      o_start_init <= 1'b0;
      o_cam_ready  <= 1'b0;
      o_fail       <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      retry        <= retry_nxt;
      o_cam_pwdn   <= (state_nxt == POR_WAIT) || (state_nxt == FAIL);
      o_cam_resetb <= !((state_nxt == POR_WAIT) || (state_nxt == PWDN_REL) || (state_nxt == FAIL));
      o_sccb_rst   <= (state_nxt == POR_WAIT) || (state_nxt == PWDN_REL) ||
                      (state_nxt == RST_REL)  || (state_nxt == FAIL);
      o_start_init <= (state_nxt == START);
      o_cam_ready  <= (state_nxt == DONE);
      o_fail       <= (state_nxt == FAIL);
    end
  end

  assign o_state     = state;
  assign o_retry_cnt = retry;

endmodule

// File: tb/tb_ov5642_pwr_seq.sv
// Bench for ov5642_pwr_seq: directed cases with literal expectations plus a randomized run
// checked every cycle against a timeline model (outputs derived from cycles since attempt start).
module tb_ov5642_pwr_seq;

  localparam int P_CLK  = 1_000_000;
  localparam int P_PWR  = 4;
  localparam int P_RST  = 3;
  localparam int P_BOOT = 5;
  localparam int P_INIT = 50;
  localparam int P_MAXR = 2;

  // attempt timeline, in cycles from the first cycle of an attempt
  localparam int E_PWDN_OFF = P_PWR;
  localparam int E_RESETB   = E_PWDN_OFF + P_RST;
  localparam int E_ARM      = E_RESETB + P_BOOT;
  localparam int E_START    = E_ARM + 1;
  localparam int E_W0       = E_START + 1;
  localparam int E_W1       = E_W0 + P_INIT - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic restart = 1'b0;
  logic init_done = 1'b0;
  logic init_err = 1'b0;
  logic cam_pwdn, cam_resetb, sccb_rst, start_init, cam_ready, fail;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int base = 0;

  ov5642_pwr_seq #(
    .CLK_FREQ(P_CLK), .T_PWR_US(P_PWR), .T_RST_US(P_RST),
    .T_BOOT_US(P_BOOT), .T_INIT_US(P_INIT), .MAX_RETRY(P_MAXR)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_restart(restart),
    .i_init_done(init_done), .i_init_err(init_err),
    .o_cam_pwdn(cam_pwdn), .o_cam_resetb(cam_resetb), .o_sccb_rst(sccb_rst),
    .o_start_init(start_init), .o_cam_ready(cam_ready), .o_fail(fail),
    .o_retry_cnt(retry_cnt), .o_state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  // mode 0: running an attempt that began at cycle m_t0; 1: configured; 2: gave up
  int m_mode = 0;
  int m_t0 = 0;
  int m_retries = 0;
  bit m_valid = 1'b0;

  function automatic logic [10:0] model_out(input int mode, input int e, input int retries);
    logic pw, rb, sr, st, rd, fl;
    int s;
    pw = 0; rb = 0; sr = 0; st = 0; rd = 0; fl = 0; s = 0;
    if (mode == 1) begin
      rb = 1; rd = 1; s = 6;
    end else if (mode == 2) begin
      pw = 1; sr = 1; fl = 1; s = 7;
    end else begin
      pw = (e < E_PWDN_OFF);
      rb = (e >= E_RESETB);
      sr = (e < E_ARM);
      st = (e == E_START);
      s  = (e < E_PWDN_OFF) ? 0 : (e < E_RESETB) ? 1 : (e < E_ARM) ? 2 :
           (e == E_ARM) ? 3 : (e == E_START) ? 4 : 5;
    end
    return {pw, rb, sr, st, rd, fl, 2'(retries), 3'(s)};
  endfunction

  always @(negedge clk) begin
    logic [10:0] exp_v, act_v;
    int e;
    e = cyc - m_t0;
    if (m_valid) begin
      exp_v = model_out(m_mode, e, m_retries);
      act_v = {cam_pwdn, cam_resetb, sccb_rst, start_init, cam_ready, fail, retry_cnt, state};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL model_cmp cyc=%0d got {pwdn,resetb,sccb_rst,start,ready,fail,retry,state}=%b expected %b",
                 cyc, act_v, exp_v);
      end
    end
    if (rst) begin
      m_valid = 1'b1;
      m_mode = 0;
      m_t0 = cyc + 1;
      m_retries = 0;
    end else if (m_valid) begin
      if (m_mode == 0) begin
        if (e >= E_W0 && e <= E_W1) begin
          if (init_err || (e == E_W1 && !init_done)) begin
            if (m_retries < P_MAXR) begin
              m_retries++;
              m_t0 = cyc + 1;
            end else begin
              m_mode = 2;
            end
          end else if (init_done) begin
            m_mode = 1;
          end
        end
      end else if (restart) begin
        m_mode = 0;
        m_retries = 0;
        m_t0 = cyc + 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    restart = 1'b0;
    init_done = 1'b0;
    init_err = 1'b0;
  endtask

  task automatic go(input int n);
    while ((cyc - base) < n) step();
  endtask

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s rel_cyc=%0d got %0d expected %0d", nm, cyc - base, act, exp_v);
    end
  endtask

  task automatic do_reset();
    step(); rst = 1'b1;
    step();
    step(); rst = 1'b0;
    base = cyc;
  endtask

  int rst_hold = 0;
  int done_div = 20;

  initial begin
    // plain power-up, then init done
    do_reset();
    chk("rst_state", int'(state), 0);
    chk("rst_retry", int'(retry_cnt), 0);
    chk("rst_ready", int'(cam_ready), 0);
    go(3);  chk("pwdn_c3", int'(cam_pwdn), 1);
    go(4);  chk("pwdn_c4", int'(cam_pwdn), 0);
    go(5);  init_done = 1'b1;
    go(6);  chk("resetb_c6", int'(cam_resetb), 0); chk("done_ignored_state", int'(state), 1);
    go(7);  chk("resetb_c7", int'(cam_resetb), 1);
    go(11); chk("sccb_c11", int'(sccb_rst), 1);
    go(12); chk("sccb_c12", int'(sccb_rst), 0); chk("start_c12", int'(start_init), 0);
    go(13); chk("start_c13", int'(start_init), 1);
    go(14); chk("start_c14", int'(start_init), 0); chk("state_c14", int'(state), 5);
    go(30); chk("ready_c30", int'(cam_ready), 0); init_done = 1'b1;
    go(31); chk("ready_c31", int'(cam_ready), 1); chk("retry_c31", int'(retry_cnt), 0);
    go(40); chk("ready_c40", int'(cam_ready), 1);

    // one error, then success on the retry
    do_reset();
    go(20); init_err = 1'b1;
    go(21);
    chk("err_pwdn", int'(cam_pwdn), 1); chk("err_resetb", int'(cam_resetb), 0);
    chk("err_sccb", int'(sccb_rst), 1); chk("err_retry", int'(retry_cnt), 1);
    go(33); chk("start2_c33", int'(start_init), 0);
    go(34); chk("start2_c34", int'(start_init), 1);
    go(40); init_done = 1'b1;
    go(41); chk("ready2_c41", int'(cam_ready), 1);

    // error on every attempt, then restart
    do_reset();
    go(20); init_err = 1'b1;
    go(41); init_err = 1'b1;
    go(62); init_err = 1'b1;
    go(63);
    chk("fail_flag", int'(fail), 1); chk("fail_retry", int'(retry_cnt), 2);
    chk("fail_state", int'(state), 7); chk("fail_pwdn", int'(cam_pwdn), 1);
    for (int n = 64; n < 100; n++) begin
      go(n);
      chk("no_start_in_fail", int'(start_init), 0);
    end
    go(100); restart = 1'b1;
    go(101);
    chk("restart_retry", int'(retry_cnt), 0); chk("restart_fail", int'(fail), 0);
    chk("restart_state", int'(state), 0);
    go(114); chk("restart_start", int'(start_init), 1);

    // no response: timeout; restart outside DONE/FAIL is ignored
    do_reset();
    go(30); restart = 1'b1;
    go(31); chk("restart_ignored", int'(state), 5);
    go(63); chk("to_state_c63", int'(state), 5);
    go(64); chk("to_state_c64", int'(state), 0); chk("to_retry_c64", int'(retry_cnt), 1);

    // reset mid-delay, then done+err together
    do_reset();
    go(9); rst = 1'b1;
    step(); rst = 1'b0;
    base = cyc;
    chk("midrst_state", int'(state), 0); chk("midrst_pwdn", int'(cam_pwdn), 1);
    chk("midrst_resetb", int'(cam_resetb), 0); chk("midrst_sccb", int'(sccb_rst), 1);
    go(3); chk("midrst_c3", int'(state), 0);
    go(4); chk("midrst_c4", int'(state), 1);
    go(20); init_done = 1'b1; init_err = 1'b1;
    go(21);
    chk("both_ready", int'(cam_ready), 0); chk("both_retry", int'(retry_cnt), 1);
    chk("both_state", int'(state), 0);

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 6000; i++) begin
      step();
      if (i % 600 == 0) done_div = (i % 1800 == 0) ? 20 : (i % 1200 == 0) ? 400 : 60;
      if (rst_hold > 0) begin
        rst = 1'b1;
        rst_hold--;
      end else begin
        rst = 1'b0;
        if ($urandom_range(0, 499) == 0) begin
          rst = 1'b1;
          rst_hold = $urandom_range(0, 2);
        end
      end
      init_done = ($urandom_range(0, done_div - 1) == 0);
      init_err  = ($urandom_range(0, 89) == 0);
      restart   = ($urandom_range(0, 24) == 0);
    end
    rst = 1'b0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
